// File: rtl/rx_channel_arbiter.sv
// rx_channel_arbiter
//   Round-robin scheduler merging CNO per-channel RX FIFOs into a single
//   output FIFO stream. Each grant moves up to BURST words from one channel;
//   every written word is tagged with its source channel. A one-word hold
//   register absorbs the read that is still in flight when the output FIFO
//   fills, so a grant never loses data.
//
// Ports
//   clk, rst_n   consolidation clock, asynchronous active-low reset
//   enable       allows new grants (and new reads inside a grant)
//   channel_up   per-channel link up
//   in_empty     per-channel FIFO empty
//   in_rd        per-channel FIFO read strobe, one-hot or zero (combinational)
//   in_data      per-channel read data, valid the cycle after in_rd
//   out_full     output FIFO full, suppresses writes
//   out_wren     output write strobe (combinational)
//   out_data     output word (combinational)
//   out_chan     source channel of out_data
//   out_first    first write of the current grant
//   grant_chan   channel currently or last granted
//   busy         scheduler not idle
//   words_total  running count of written words, wraps at 2**32
module rx_channel_arbiter #(
  parameter int unsigned CNO   = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned CHW   = 3,
  parameter int unsigned BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNO-1:0]    channel_up,
  input  logic [CNO-1:0]    in_empty,
  output logic [CNO-1:0]    in_rd,
  input  logic [DW*CNO-1:0] in_data,
  input  logic              out_full,
  output logic              out_wren,
  output logic [DW-1:0]     out_data,
  output logic [CHW-1:0]    out_chan,
  output logic              out_first,
  output logic [CHW-1:0]    grant_chan,
  output logic              busy,
  output logic [31:0]       words_total
);

  localparam int unsigned BCW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CHW-1:0]    ptr_q;
  logic [CHW-1:0]    grant_q;
  logic [BCW-1:0]    burst_cnt_q;
  logic              rd_pend_q;
  logic              hold_v_q;
  logic [DW-1:0]     hold_data_q;
  logic              first_q;
  logic [31:0]       words_q;

  logic [CNO-1:0]    elig;
  logic              arb_found;
  logic [CHW-1:0]    arb_chan;
  logic              g_up;
  logic              g_empty;
  logic [DW-1:0]     g_data;
  logic              rd_issue;
  logic              grant_load;
  logic              ptr_load;

  assign elig = {CNO{enable}} & channel_up & ~in_empty;

  // First eligible channel at or after ptr, searching cyclically
  always_comb begin
    int idx;
    arb_found = 1'b0;
    arb_chan  = '0;
    idx       = 0;
    for (int i = 0; i < int'(CNO); i++) begin
      idx = (int'(ptr_q) + i) % int'(CNO);
      if (!arb_found && elig[idx]) begin
        arb_found = 1'b1;
        arb_chan  = CHW'(idx);
      end
    end
  end

  // Status and data of the granted channel
  always_comb begin
    g_up    = 1'b0;
    g_empty = 1'b1;
    g_data  = '0;
    for (int c = 0; c < int'(CNO); c++) begin
      if (grant_q == CHW'(c)) begin
        g_up    = channel_up[c];
        g_empty = in_empty[c];
        g_data  = in_data[c*DW +: DW];
      end
    end
  end

  // Next-state and read-issue logic
  always_comb begin
    state_d    = state_q;
    rd_issue   = 1'b0;
    in_rd      = '0;
    grant_load = 1'b0;
    ptr_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_load = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        // enable qualifies the read so a dropped enable stops new reads at once
        rd_issue = enable & g_up & ~g_empty & ~out_full & ~hold_v_q &
                   (burst_cnt_q < BCW'(BURST));
        for (int c = 0; c < int'(CNO); c++) begin
          in_rd[c] = rd_issue & (grant_q == CHW'(c));
        end
        if ((burst_cnt_q + BCW'(rd_issue)) == BCW'(BURST) ||
            g_empty || !g_up || !enable) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_pend_q && !hold_v_q) begin
          state_d  = IDLE;
          ptr_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant bookkeeping, hold register and word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
      first_q     <= 1'b0;
      words_q     <= '0;
    end else begin
      rd_pend_q <= rd_issue;
      words_q   <= words_q + 32'(out_wren);

      if (grant_load) begin
        grant_q     <= arb_chan;
        burst_cnt_q <= '0;
        first_q     <= 1'b1;
      end else begin
        if (rd_issue) burst_cnt_q <= burst_cnt_q + BCW'(1);
        if (out_wren) first_q <= 1'b0;
      end

      if (ptr_load) begin
        ptr_q <= (grant_q == CHW'(CNO - 1)) ? '0 : grant_q + CHW'(1);
      end

      // Returning word meets a full output: park it until space frees up
      if (rd_pend_q && out_full) begin
        hold_v_q    <= 1'b1;
        hold_data_q <= g_data;
      end else if (hold_v_q && !out_full) begin
        hold_v_q <= 1'b0;
      end
    end
  end

  // Hold and a returning read are never valid together: no read issues while hold_v_q
  assign out_wren    = (rd_pend_q | hold_v_q) & ~out_full;
  assign out_data    = hold_v_q ? hold_data_q : g_data;
  assign out_chan    = grant_q;
  assign out_first   = out_wren & first_q;
  assign grant_chan  = grant_q;
  assign busy        = (state_q != IDLE);
  assign words_total = words_q;

endmodule

// File: tb/tb_rx_channel_arbiter.sv
// Testbench for rx_channel_arbiter: bench-side FIFO models feed the DUT,
// every pushed word is queued per channel in a scoreboard and a negedge
// monitor checks each written word, its tag, grant boundaries and counters.
module tb_rx_channel_arbiter;

  localparam int unsigned CNO   = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned CHW   = 3;
  localparam int unsigned BURST = 4;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [CNO-1:0]    channel_up;
  logic [CNO-1:0]    in_empty;
  logic [CNO-1:0]    in_rd;
  logic [DW*CNO-1:0] in_data;
  logic              out_full;
  logic              out_wren;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_chan;
  logic              out_first;
  logic [CHW-1:0]    grant_chan;
  logic              busy;
  logic [31:0]       words_total;

  rx_channel_arbiter #(.CNO(CNO), .DW(DW), .CHW(CHW), .BURST(BURST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .channel_up  (channel_up),
    .in_empty    (in_empty),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .out_full    (out_full),
    .out_wren    (out_wren),
    .out_data    (out_data),
    .out_chan    (out_chan),
    .out_first   (out_first),
    .grant_chan  (grant_chan),
    .busy        (busy),
    .words_total (words_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] fifo  [CNO][$];   // contents of each input FIFO
  logic [DW-1:0] exp_q [CNO][$];   // words still owed to the output, per channel
  int            grant_exp[$];     // expected sequence of granted channels
  int            len_exp[$];       // expected words per grant (0 = unchecked)
  int            rd_cnt[CNO];
  logic [CNO-1:0] rd_s;

  // monitor state
  int wt;
  int wr_seen     = 0;
  bit nf;
  int cur_len;
  int cur_len_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < int'(CNO); c++) s += exp_q[c].size();
    return s;
  endfunction

  task automatic refresh();
    for (int c = 0; c < int'(CNO); c++) in_empty[c] = (fifo[c].size() == 0);
  endtask

  task automatic push(input int c, input logic [DW-1:0] w);
    fifo[c].push_back(w);
    exp_q[c].push_back(w);
    refresh();
  endtask

  task automatic flush();
    for (int c = 0; c < int'(CNO); c++) begin
      fifo[c].delete();
      exp_q[c].delete();
      rd_cnt[c] = 0;
    end
    grant_exp.delete();
    len_exp.delete();
    in_data = '0;
    refresh();
  endtask

  // One clock: sample reads at negedge, deliver read data just after posedge
  task automatic step(input bit want_wr = 1'b0);
    @(negedge clk);
    if (want_wr) chk("write_expected", out_wren, 1);
    rd_s = in_rd;
    @(posedge clk);
    #1;
    for (int c = 0; c < int'(CNO); c++) begin
      if (rd_s[c]) begin
        chk("read_nonempty", fifo[c].size() != 0, 1);
        if (fifo[c].size() != 0) in_data[c*DW +: DW] = fifo[c].pop_front();
        rd_cnt[c]++;
      end
    end
    refresh();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_rd"}, in_rd, 0);
    chk({tag, "_out_wren"}, out_wren, 0);
    chk({tag, "_out_first"}, out_first, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_words_total"}, words_total, 0);
    chk({tag, "_grant_chan"}, grant_chan, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_zero(tag);
    enable     = 1'b1;
    channel_up = '1;
    out_full   = 1'b0;
    flush();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((pending() != 0 || busy) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_done", n < maxc, 1);
    if (cur_len_exp != 0) chk("chunk_len_last", cur_len, cur_len_exp);
    cur_len_exp = 0;
  endtask

  task automatic wait_rd(input int c, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!rd_s[c] && n < 100);
    chk(name, rd_s[c], 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      wt          = 0;
      nf          = 1'b1;
      cur_len     = 0;
      cur_len_exp = 0;
    end else begin
      chk("rd_onehot", $countones(in_rd) <= 1, 1);
      if (in_rd != 0) chk("rd_on_grant", in_rd, 8'(1) << grant_chan);
      if (out_full) begin
        chk("full_no_write", out_wren, 0);
        chk("full_no_read", in_rd, 0);
      end
      if (out_wren) begin
        chk("out_first", out_first, nf);
        if (nf) begin
          if (cur_len_exp != 0) chk("chunk_len", cur_len, cur_len_exp);
          cur_len_exp = 0;
          if (grant_exp.size() != 0) begin
            chk("grant_order", out_chan, grant_exp.pop_front());
            cur_len_exp = len_exp.pop_front();
          end
          cur_len = 0;
          nf      = 1'b0;
        end
        cur_len++;
        chk("burst_max", cur_len <= int'(BURST), 1);
        chk("chan_is_grant", out_chan, grant_chan);
        chk("words_total", words_total, wt);
        wt++;
        wr_seen++;
        chk("word_expected", exp_q[out_chan].size() != 0, 1);
        if (exp_q[out_chan].size() != 0) chk("out_data", out_data, exp_q[out_chan].pop_front());
      end else begin
        chk("first_without_write", out_first, 0);
      end
      if (!busy) nf = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst_n      = 1'b0;
    enable     = 1'b1;
    channel_up = '1;
    out_full   = 1'b0;
    in_data    = '0;
    flush();
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // T1: three words on ch2
    push(2, 32'hA000_000A);
    push(2, 32'hB000_000B);
    push(2, 32'hC000_000C);
    grant_exp.push_back(2); len_exp.push_back(3);
    drain(50);
    chk("t1_reads", rd_cnt[2], 3);
    chk("t1_total", words_total, 3);

    // T2: three loaded channels, round-robin in BURST chunks
    do_reset("t2_reset");
    for (int i = 0; i < 10; i++) begin
      push(0, $urandom);
      push(3, $urandom);
      push(7, $urandom);
    end
    for (int r = 0; r < 3; r++) begin
      foreach (grant_exp[k]) begin end
      grant_exp.push_back(0); len_exp.push_back(r < 2 ? 4 : 2);
      grant_exp.push_back(3); len_exp.push_back(r < 2 ? 4 : 2);
      grant_exp.push_back(7); len_exp.push_back(r < 2 ? 4 : 2);
    end
    drain(400);
    chk("t2_total", words_total, 30);

    // T3: output full for 5 cycles right after a read
    for (int i = 0; i < 12; i++) push(1, $urandom);
    wait_rd(1, "t3_read_seen");
    out_full = 1'b1;
    repeat (5) step();
    out_full = 1'b0;
    step(1'b1);
    drain(200);

    // T4: ch5 link drops mid-burst, next grant goes to ch6
    do_reset("t4_reset");
    for (int i = 0; i < 10; i++) push(5, $urandom);
    push(6, $urandom);
    push(6, $urandom);
    grant_exp.push_back(5); len_exp.push_back(0);
    grant_exp.push_back(6); len_exp.push_back(2);
    grant_exp.push_back(5); len_exp.push_back(0);
    wait_rd(5, "t4_read_seen");
    step();
    channel_up[5] = 1'b0;
    step(1'b1);
    channel_up[5] = 1'b1;
    drain(300);

    // T5: reset mid-burst, pointer restarts at 0
    for (int i = 0; i < 8; i++) push(4, $urandom);
    wait_rd(4, "t5_read_seen");
    step();
    do_reset("t5_reset");
    push(3, $urandom); push(3, $urandom);
    push(6, $urandom); push(6, $urandom);
    grant_exp.push_back(3); len_exp.push_back(2);
    grant_exp.push_back(6); len_exp.push_back(2);
    drain(100);

    // T6: enable drops with words left in the grant
    for (int i = 0; i < 3; i++) push(4, $urandom);
    wait_rd(4, "t6_read_seen");
    enable = 1'b0;
    w0 = wr_seen;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t6_no_read", rd_s, 0);
    end
    chk("t6_writes_after_drop", wr_seen - w0, 1);
    chk("t6_idle", busy, 0);
    enable = 1'b1;
    drain(100);

    // Randomised traffic with back-pressure, link flaps and enable drops
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) push($urandom_range(0, CNO - 1), $urandom);
      out_full   = ($urandom_range(0, 4) == 0);
      enable     = ($urandom_range(0, 24) != 0);
      channel_up = '1;
      if ($urandom_range(0, 39) == 0) channel_up[$urandom_range(0, CNO - 1)] = 1'b0;
      step();
    end
    enable     = 1'b1;
    channel_up = '1;
    out_full   = 1'b0;
    drain(3000);
    chk("final_pending", pending(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
